// File: rtl/c5_mult_arb.sv
// Two-requester round-robin front end for a shared multiply/divide unit.
// Each request is issued, polled until the unit finishes (or times out), and the result is returned to its owner.
module c5_mult_arb #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 48
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic [1:0]       I_req,
  input  logic [1:0]       I_op0,
  input  logic [1:0]       I_op1,
  input  logic [WIDTH-1:0] I_a0,
  input  logic [WIDTH-1:0] I_b0,
  input  logic [WIDTH-1:0] I_a1,
  input  logic [WIDTH-1:0] I_b1,
  output logic [1:0]       O_gnt,
  output logic [1:0]       O_done,
  output logic             O_err,
  output logic [WIDTH-1:0] O_lo,
  output logic [WIDTH-1:0] O_hi,
  output logic             O_busy,
  output logic [3:0]       O_mult_func,
  output logic [WIDTH-1:0] O_a,
  output logic [WIDTH-1:0] O_b,
  input  logic [WIDTH-1:0] I_c_mult,
  input  logic             I_pause
);

  localparam logic [3:0] MULT_NOTHING       = 4'd0;
  localparam logic [3:0] MULT_MULT          = 4'd1;
  localparam logic [3:0] MULT_SIGNED_MULT   = 4'd2;
  localparam logic [3:0] MULT_DIVIDE        = 4'd3;
  localparam logic [3:0] MULT_SIGNED_DIVIDE = 4'd4;
  localparam logic [3:0] MULT_READ_LO       = 4'd5;
  localparam logic [3:0] MULT_READ_HI       = 4'd6;

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_READ_HI, S_DONE} state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic [CW-1:0]    wait_cnt;
  logic [WIDTH-1:0] lo_cap;
  logic             win;
  logic [1:0]       win_op;
  logic [3:0]       start_func;
  logic [1:0]       owner_hot;

  // On a tie the requester that was not served last wins; last resets to 1 so requester 0 goes first.
  assign win       = (I_req == 2'b11) ? ~last : I_req[1];
  assign win_op    = win ? I_op1 : I_op0;
  assign owner_hot = owner ? 2'b10 : 2'b01;
  assign O_busy    = (state != S_IDLE);

  // Grant is decided in the IDLE cycle itself; holding it low in reset keeps the pulse clean during reset.
  assign O_gnt = (I_rst_n && state == S_IDLE && |I_req) ? (win ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    // NOTE: default assignment first so no path leaves start_func unassigned, which would infer a latch.
    start_func = MULT_MULT;
    case (win_op)
      2'd1:    start_func = MULT_SIGNED_MULT;
      2'd2:    start_func = MULT_DIVIDE;
      2'd3:    start_func = MULT_SIGNED_DIVIDE;
      default: start_func = MULT_MULT;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      wait_cnt    <= '0;
      lo_cap      <= '0;
      O_done      <= 2'b00;
      O_err       <= 1'b0;
      O_lo        <= '0;
      O_hi        <= '0;
      O_mult_func <= MULT_NOTHING;
      O_a         <= '0;
      O_b         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|I_req) begin
            owner       <= win;
            O_mult_func <= start_func;
            O_a         <= win ? I_a1 : I_a0;
            O_b         <= win ? I_b1 : I_b0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          O_mult_func <= MULT_READ_LO;
          O_a         <= '0;
          O_b         <= '0;
          wait_cnt    <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (!I_pause) begin
            lo_cap      <= I_c_mult;
            O_mult_func <= MULT_READ_HI;
            state       <= S_READ_HI;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // Abort after exactly TIMEOUT stalled WAIT cycles; results are forced to zero.
            O_err       <= 1'b1;
            O_lo        <= '0;
            O_hi        <= '0;
            O_done      <= owner_hot;
            O_mult_func <= MULT_NOTHING;
            state       <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_READ_HI: begin
          O_lo        <= lo_cap;
          O_hi        <= I_c_mult;
          O_err       <= 1'b0;
          O_done      <= owner_hot;
          O_mult_func <= MULT_NOTHING;
          state       <= S_DONE;
        end
        S_DONE: begin
          O_done <= 2'b00;
          O_err  <= 1'b0;
          last   <= owner;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/c5_mult_arb.md
C5_MULT_ARB -- requirements
Module: c5_mult_arb

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter TIMEOUT, default 48, maximum WAIT-state cycles before abort.
REQ-003 I_clk  input  1  single clock; all state changes on rising edge.
REQ-004 I_rst_n  input  1  asynchronous, active-low reset.
REQ-005 I_req  input  2  per-requester request level; bit i held high until O_gnt[i].
REQ-006 I_op0, I_op1  input  2 each  operation: 0 unsigned mult, 1 signed mult, 2 unsigned div, 3 signed div.
REQ-007 I_a0, I_b0, I_a1, I_b1  input  WIDTH each  operands per requester, stable while request pending.
REQ-008 O_gnt  output  2  one-cycle, one-hot acceptance pulse; operands sampled that cycle.
REQ-009 O_done  output  2  one-cycle, one-hot completion pulse to the owning requester.
REQ-010 O_err  output  1  high with O_done when the operation timed out.
REQ-011 O_lo, O_hi  output  WIDTH each  result (mult: low/high product; div: quotient/remainder), held until next O_done.
REQ-012 O_busy  output  1  high in every state except IDLE.
REQ-013 O_mult_func  output  4  function code to shared mult/div unit, MULT_* encodings from c5_parameters.v.
REQ-014 O_a, O_b  output  WIDTH each  operands to shared unit.
REQ-015 I_c_mult  input  WIDTH  shared unit read data.
REQ-016 I_pause  input  1  shared unit busy flag (valid while a READ code is driven).

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, READ_HI, DONE; transitions only as in REQ-018..REQ-024.
REQ-018 IDLE: if any I_req bit set, assert O_gnt for the winner, latch its op/operands and owner id, go ISSUE; else stay.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests the requester not most recently granted wins; after reset requester 0 has priority.
REQ-020 ISSUE (1 cycle): drive O_mult_func = MULT_MULT / MULT_SIGNED_MULT / MULT_DIVIDE / MULT_SIGNED_DIVIDE per latched op, O_a/O_b = latched operands; go WAIT, clear wait counter.
REQ-021 WAIT: drive MULT_READ_LO; if I_pause = 0 capture I_c_mult as low result, go READ_HI; else increment wait counter.
REQ-022 WAIT: if wait counter reaches TIMEOUT with I_pause still 1, set error flag, zero captured results, go DONE.
REQ-023 READ_HI (1 cycle): drive MULT_READ_HI, capture I_c_mult as high result, go DONE.
REQ-024 DONE (1 cycle): pulse O_done[owner], O_err = error flag, update O_lo/O_hi from captured values, update round-robin pointer, go IDLE.
REQ-025 In all states other than ISSUE/WAIT/READ_HI, O_mult_func SHALL be MULT_NOTHING; O_a/O_b SHALL be 0 outside ISSUE.
REQ-026 No new grant while O_busy = 1; requests arriving meanwhile remain pending and are arbitrated in the next IDLE cycle.
REQ-027 Earliest next grant is the cycle after DONE; a requester may reassert I_req the cycle after its O_gnt.
REQ-028 Uncontended latency (shared unit 32-cycle op): grant at T, ISSUE T+1, I_pause low at T+34, READ_HI T+35, O_done T+36.
REQ-029 Results, signs and divide-by-zero values SHALL be passed through unmodified from the shared unit.
REQ-030 O_gnt, O_done and O_err SHALL never be high for more than one consecutive cycle.

Reset
REQ-031 On I_rst_n low, immediately: state IDLE, O_gnt = 0, O_done = 0, O_err = 0, O_lo = O_hi = 0, O_busy = 0, O_mult_func = MULT_NOTHING, O_a = O_b = 0, round-robin pointer favours requester 0, wait counter 0.
REQ-032 Reset asserted mid-operation SHALL abandon the operation with no O_done; the pending requester must re-request.

Verification
REQ-033 Req0 op0 a=0x00010000 b=0x00010000 -> O_gnt=01 at T, O_done=01 at T+36, O_hi=0x00000001, O_lo=0x00000000, O_err=0.
REQ-034 Req1 op2 a=100 b=7 -> O_done=10, O_lo=14, O_hi=2.
REQ-035 I_req=11 held continuously -> grants alternate 01,10,01,10; each O_done matches preceding grant owner.
REQ-036 Shared-unit model holds I_pause=1 forever -> O_done with O_err=1 after TIMEOUT WAIT cycles, O_lo=O_hi=0, FSM back to IDLE.
REQ-037 Assert I_rst_n low during WAIT -> all outputs reach reset values without a clock edge; no O_done; next request served normally.
REQ-038 Req0 op3 a=-7 b=2 with reference unit model -> O_lo/O_hi equal model READ_LO/READ_HI values bit-for-bit.
